hazard_scoreboard: RTL

- Parametrised hazard and forwarding controller for the in-order MIPS pipeline. It sits beside the D stage.
- It keeps its own shadow of the post-decode stages (E, M, W, ...): destination register, write enable, remaining Tnew.
- It makes the Tuse/Tnew stall decision, picks the forwarding source for rs/rt, and models multi-cycle MDU occupancy with an internal countdown, so no external Busy/Start is needed.
- It also counts stall cycles for performance analysis.

---
 rtl/hazard_scoreboard_pkg.sv | 23 ++
 rtl/hazard_src_check.sv | 56 +++++
 rtl/hazard_scoreboard.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared defaults and shadow-entry layout for the D-stage hazard scoreboard.
// An entry is packed as {v, we, addr, tnew} with tnew in the low bits.
package hazard_scoreboard_pkg;

    localparam int DEF_NSTAGE   = 3;
    localparam int DEF_REG_AW   = 5;
    localparam int DEF_T_W      = 2;
    localparam int DEF_MULT_CYC = 5;
    localparam int DEF_DIV_CYC  = 10;

    function automatic int entry_w(input int aw, input int tw);
        return aw + tw + 2;
    endfunction

    function automatic int we_bit(input int aw, input int tw);
        return aw + tw;
    endfunction

    function automatic int v_bit(input int aw, input int tw);
        return aw + tw + 1;
    endfunction

endpackage

// File: rtl/hazard_src_check.sv
// Priority scan of the shadow pipe for one D-stage source operand.
// Returns the data-stall request and the forwarding select for that source.
module hazard_src_check
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSTAGE = DEF_NSTAGE,
    parameter int REG_AW = DEF_REG_AW,
    parameter int T_W    = DEF_T_W,
    parameter int SEL_W  = $clog2(NSTAGE + 1)
) (
    input  logic [NSTAGE*entry_w(REG_AW, T_W)-1:0] entries,
    input  logic [REG_AW-1:0]                      src_addr,
    input  logic [T_W-1:0]                         src_tuse,
    output logic                                   stall_s,
    output logic [SEL_W-1:0]                       sel_s
);

    localparam int EW   = entry_w(REG_AW, T_W);
    localparam int WE_B = we_bit(REG_AW, T_W);
    localparam int V_B  = v_bit(REG_AW, T_W);

    logic [EW-1:0]    ent_s;
    logic             hit_s;
    logic [T_W-1:0]   hit_tnew_s;
    logic [SEL_W-1:0] hit_sel_s;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        ent_s      = '0;
        hit_s      = 1'b0;
        hit_tnew_s = '0;
        hit_sel_s  = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            ent_s = entries[k*EW +: EW];
            if (ent_s[V_B] && ent_s[WE_B] && (ent_s[T_W +: REG_AW] == src_addr) &&
                (src_addr != '0)) begin
                hit_s      = 1'b1;
                hit_tnew_s = ent_s[T_W-1:0];
                hit_sel_s  = SEL_W'(k + 1);
            end else begin
                hit_s      = hit_s;
            end
        end
    end

    // The select names the producer stage whenever the value is ready in time.
    always_comb begin
        stall_s = hit_s && (src_tuse < hit_tnew_s);
        if (hit_s && !stall_s) begin
            sel_s = hit_sel_s;
        end else begin
            sel_s = '0;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard and forwarding controller beside the D stage, with an
// internal MDU occupancy countdown and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSTAGE   = DEF_NSTAGE,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int T_W      = DEF_T_W,
    parameter int MULT_CYC = DEF_MULT_CYC,
    parameter int DIV_CYC  = DEF_DIV_CYC,
    parameter int SEL_W    = $clog2(NSTAGE + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [T_W-1:0]    rs_tuse,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [T_W-1:0]    rt_tuse,
    input  logic              dst_we,
    input  logic [REG_AW-1:0] dst_addr,
    input  logic [T_W-1:0]    dst_tnew,
    input  logic              mdu_start,
    input  logic              mdu_is_div,
    input  logic              mdu_acc,
    output logic              stall,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_clr,
    output logic [SEL_W-1:0]  fwd_rs_sel,
    output logic [SEL_W-1:0]  fwd_rt_sel,
    output logic              mdu_busy,
    output logic [31:0]       stall_cnt
);

    localparam int EW      = entry_w(REG_AW, T_W);
    localparam int MDU_MAX = ((DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC) + 1;
    localparam int CNT_W   = $clog2(MDU_MAX + 1);

    logic [EW-1:0]        shadow_r [NSTAGE];
    logic [EW-1:0]        shadow_nxt_s [NSTAGE];
    logic [NSTAGE*EW-1:0] shadow_flat_s;
    logic                 rs_stall_s;
    logic                 rt_stall_s;
    logic                 mdu_stall_s;
    logic                 stall_s;
    logic [CNT_W-1:0]     mdu_cnt_r;
    logic [31:0]          stall_cnt_r;

    // Flatten the shadow pipe for the source checkers.
    always_comb begin
        shadow_flat_s = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            shadow_flat_s[k*EW +: EW] = shadow_r[k];
        end
    end

    hazard_src_check #(
        .NSTAGE (NSTAGE),
        .REG_AW (REG_AW),
        .T_W    (T_W),
        .SEL_W  (SEL_W)
    ) u_rs_check (
        .entries  (shadow_flat_s),
        .src_addr (rs_addr),
        .src_tuse (rs_tuse),
        .stall_s  (rs_stall_s),
        .sel_s    (fwd_rs_sel)
    );

    hazard_src_check #(
        .NSTAGE (NSTAGE),
        .REG_AW (REG_AW),
        .T_W    (T_W),
        .SEL_W  (SEL_W)
    ) u_rt_check (
        .entries  (shadow_flat_s),
        .src_addr (rt_addr),
        .src_tuse (rt_tuse),
        .stall_s  (rt_stall_s),
        .sel_s    (fwd_rt_sel)
    );

    // Stall decision and the pipeline-enable views of it.
    always_comb begin
        mdu_busy    = (mdu_cnt_r != '0);
        mdu_stall_s = d_valid && (mdu_start || mdu_acc) && mdu_busy;
        stall_s     = d_valid && (rs_stall_s || rt_stall_s || mdu_stall_s);
        stall       = stall_s;
        pc_en       = !stall_s;
        ifid_en     = !stall_s;
        idex_clr    = stall_s;
        stall_cnt   = stall_cnt_r;
    end

    // Next shadow: a stalled D enters E as a bubble; older tnew counts down to 0.
    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            shadow_nxt_s[k] = '0;
        end
        shadow_nxt_s[0] = {d_valid && !stall_s, dst_we, dst_addr, dst_tnew};
        for (int k = 1; k < NSTAGE; k++) begin
            if (shadow_r[k-1][T_W-1:0] == '0) begin
                shadow_nxt_s[k] = shadow_r[k-1];
            end else begin
                shadow_nxt_s[k] = {shadow_r[k-1][EW-1:T_W], shadow_r[k-1][T_W-1:0] - T_W'(1)};
            end
        end
    end

    // Shadow pipe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTAGE; k++) begin
                shadow_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                shadow_r[k] <= shadow_nxt_s[k];
            end
        end
    end

    // MDU occupancy: the extra cycle accounts for the E issue slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_cnt_r <= '0;
        end else if (d_valid && mdu_start && !stall_s) begin
            mdu_cnt_r <= mdu_is_div ? CNT_W'(DIV_CYC + 1) : CNT_W'(MULT_CYC + 1);
        end else if (mdu_cnt_r != '0) begin
            mdu_cnt_r <= mdu_cnt_r - CNT_W'(1);
        end else begin
            mdu_cnt_r <= mdu_cnt_r;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule
